// File: rtl/m2s_stream_arbiter.sv
// Round-robin Avalon-ST arbiter feeding the memory-to-stream FIFO sink.
// Holds each grant for up to MAX_BURST beats, tags beats with the source
// index on the channel field and registers the output toward the FIFO.
module m2s_stream_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*8-1:0]      src_error,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [7:0]                out_channel,
  output logic [7:0]                out_error,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [2:0]                grant_idx
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [2:0] LAST_RST   = 3'(NUM_SRC - 1);

  state_t              state_q, state_d;
  logic [2:0]          grant_idx_q, grant_idx_d;
  logic [2:0]          last_grant_q, last_grant_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [7:0]          out_channel_q, out_channel_d;
  logic [7:0]          out_error_q, out_error_d;

  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  grant_oh;
  logic                cur_valid;
  logic                cur_enable;
  logic [DATA_W-1:0]   cur_data;
  logic [7:0]          cur_error;
  logic                slot_free;
  logic                accept;
  logic                rel;
  logic [3:0]          pick;

  // Round-robin search: first eligible index after 'last', wrapping, with
  // 'last' itself checked at the very end. Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [NUM_SRC-1:0] el,
                                         input logic [2:0]         last);
    logic       found;
    logic [2:0] idx;
    int         cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last) + k) % NUM_SRC;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && (j == cand) && el[j]) begin
          found = 1'b1;
          idx   = 3'(j);
        end
      end
    end
    return {found, idx};
  endfunction

  assign elig      = src_valid & src_enable;
  assign slot_free = ~out_valid_q | out_ready;

  // Multiplex the currently granted source's signals.
  always_comb begin
    grant_oh   = '0;
    cur_valid  = 1'b0;
    cur_enable = 1'b0;
    cur_data   = '0;
    cur_error  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx_q == 3'(i)) begin
        grant_oh[i] = 1'b1;
        cur_valid   = src_valid[i];
        cur_enable  = src_enable[i];
        cur_data    = src_data[i*DATA_W +: DATA_W];
        cur_error   = src_error[i*8 +: 8];
      end
    end
  end

  // Arbitration FSM: grant selection, burst counting and same-cycle re-grant.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    src_ready    = '0;
    accept       = 1'b0;
    rel          = 1'b0;
    pick         = '0;
    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(elig, last_grant_q);
        if (pick[3]) begin
          grant_idx_d  = pick[2:0];
          last_grant_d = pick[2:0];
          burst_cnt_d  = '0;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        src_ready = grant_oh & {NUM_SRC{slot_free}};
        accept    = cur_valid & slot_free;
        rel       = (accept && (burst_cnt_q == BURST_LAST)) || !cur_valid || !cur_enable;
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (rel) begin
          // The released index is the lowest priority for the next search.
          pick        = rr_pick(elig, grant_idx_q);
          burst_cnt_d = '0;
          if (pick[3]) begin
            grant_idx_d  = pick[2:0];
            last_grant_d = pick[2:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: load on accept, drain on ready, hold while stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_error_d   = out_error_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = cur_data;
      out_channel_d = {5'd0, grant_idx_q};
      out_error_d   = cur_error;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= LAST_RST;
      burst_cnt_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_error_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_error_q   <= out_error_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_error   = out_error_q;
  assign busy        = (state_q == ST_GRANT);
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_m2s_stream_arbiter.sv
// Testbench for m2s_stream_arbiter: cycle table after reset, directed
// multi-cycle sequences, and randomized traffic against a per-source
// transaction scoreboard.
module tb_m2s_stream_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_SRC-1:0]        src_enable = '1;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [NUM_SRC*8-1:0]      src_error = '0;
  logic [NUM_SRC-1:0]        src_ready, src_ready1;
  logic                      out_valid, out_valid1;
  logic [DATA_W-1:0]         out_data, out_data1;
  logic [7:0]                out_channel, out_channel1, out_error, out_error1;
  logic                      out_ready = 1'b1;
  logic                      busy, busy1;
  logic [2:0]                grant_idx, grant_idx1;

  m2s_stream_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) u_dut (
    .clock(clock), .reset(reset), .src_enable(src_enable), .src_valid(src_valid),
    .src_data(src_data), .src_error(src_error), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_error(out_error), .out_ready(out_ready), .busy(busy), .grant_idx(grant_idx));

  // Second instance with single-beat grants, sharing all inputs.
  m2s_stream_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MAX_BURST(1)) u_dut1 (
    .clock(clock), .reset(reset), .src_enable(src_enable), .src_valid(src_valid),
    .src_data(src_data), .src_error(src_error), .src_ready(src_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_channel(out_channel1),
    .out_error(out_error1), .out_ready(out_ready), .busy(busy1), .grant_idx(grant_idx1));

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int                cyc;
    logic [7:0]        chan;
    logic [DATA_W-1:0] data;
  } obs_t;

  // Source-side model: beats waiting to be offered, and beats accepted but
  // not yet seen on the output.
  logic [DATA_W-1:0] pend  [NUM_SRC][$];
  logic [DATA_W-1:0] acc_q [NUM_SRC][$];
  obs_t              olog[$];
  obs_t              olog1[$];
  logic [NUM_SRC-1:0] vmask = '1;
  logic [NUM_SRC-1:0] en_r = '1;
  logic               ordy_r = 1'b1;
  int                 cyc = 0;

  logic [NUM_SRC-1:0] s_rdy;
  logic               s_ov, s_busy;
  logic [2:0]         s_grant;
  logic [DATA_W-1:0]  s_data;
  int                 s_cyc;
  logic               prev_stall = 1'b0;
  logic [DATA_W-1:0]  prev_data;
  logic [7:0]         prev_chan, prev_err;

  function automatic logic [7:0] err_of(input int i, input logic [DATA_W-1:0] d);
    return 8'(i * 37) ^ d[7:0];
  endfunction

  function automatic logic [DATA_W-1:0] beat(input int i, input int k);
    return {8'(i), 24'(k)};
  endfunction

  function automatic int backlog();
    int n = 0;
    for (int i = 0; i < NUM_SRC; i++) n += pend[i].size() + acc_q[i].size();
    return n;
  endfunction

  // One clock cycle: drive sources, sample just after the drive, score the
  // handshakes that will complete on the coming rising edge.
  task automatic tick();
    logic [NUM_SRC-1:0] acc;
    obs_t o;
    int ch;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i] = (pend[i].size() > 0) && vmask[i];
      src_data[i*DATA_W +: DATA_W] = (pend[i].size() > 0) ? pend[i][0] : '0;
      src_error[i*8 +: 8] = err_of(i, src_data[i*DATA_W +: DATA_W]);
    end
    src_enable = en_r;
    out_ready  = ordy_r;
    #1;
    s_rdy = src_ready; s_ov = out_valid; s_busy = busy; s_grant = grant_idx;
    s_data = out_data; s_cyc = cyc;
    acc = src_valid & src_ready;
    check("rdy_onehot", 64'($countones(src_ready) <= 1), 64'd1);
    check("rdy_when_full", 64'((|src_ready) && out_valid && !out_ready), 64'd0);
    if (prev_stall) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(prev_data));
      check("stall_chan", 64'(out_channel), 64'(prev_chan));
      check("stall_err", 64'(out_error), 64'(prev_err));
    end
    if (out_valid && out_ready) begin
      o.cyc = cyc; o.chan = out_channel; o.data = out_data;
      olog.push_back(o);
      ch = int'(out_channel);
      if (ch >= NUM_SRC || acc_q[ch % NUM_SRC].size() == 0) begin
        check("sb_expected_beat", 64'(out_channel), 64'hFFFF);
      end else begin
        e = acc_q[ch].pop_front();
        check("sb_data", 64'(out_data), 64'(e));
        check("sb_error", 64'(out_error), 64'(err_of(ch, e)));
      end
    end
    if (out_valid1 && out_ready) begin
      o.cyc = cyc; o.chan = out_channel1; o.data = out_data1;
      olog1.push_back(o);
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) acc_q[i].push_back(pend[i].pop_front());
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_chan = out_channel; prev_err = out_error;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_valid = '0; src_enable = '1; out_ready = 1'b1;
    en_r = '1; vmask = '1; ordy_r = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend[i].delete();
      acc_q[i].delete();
    end
    olog.delete(); olog1.delete();
    prev_stall = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  en;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic        e_busy;
    logic [2:0]  e_grant;
    logic [7:0]  e_chan;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int first_rdy, n1, first3, n3, tot, seqn[NUM_SRC];
    int idx;

    // Cycle-by-cycle table from reset; each source presents a fixed word.
    tbl[0]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0};
    tbl[1]  = '{4'b0100, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 8'd0, 32'h0};
    tbl[2]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b0, 1'b1, 3'd2, 8'd0, 32'h0};
    tbl[3]  = '{4'b0000, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 3'd2, 8'd2, 32'hD000_0002};
    tbl[4]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd2, 8'd2, 32'hD000_0002};
    tbl[5]  = '{4'b1010, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd2, 8'd2, 32'hD000_0002};
    tbl[6]  = '{4'b1010, 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b1, 3'd3, 8'd2, 32'hD000_0002};
    tbl[7]  = '{4'b1010, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3, 8'd3, 32'hD000_0003};
    tbl[8]  = '{4'b1010, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3, 8'd3, 32'hD000_0003};
    tbl[9]  = '{4'b1010, 4'b0111, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd1, 8'd3, 32'hD000_0003};
    tbl[10] = '{4'b0000, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 3'd1, 8'd1, 32'hD000_0001};
    tbl[11] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd1, 8'd1, 32'hD000_0001};

    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
      src_error[i*8 +: 8] = 8'hE0 + 8'(i);
    end
    for (int k = 0; k < 12; k++) begin
      src_valid = tbl[k].valid; src_enable = tbl[k].en; out_ready = tbl[k].ordy;
      #1;
      check($sformatf("tbl%0d_src_ready", k), 64'(src_ready), 64'(tbl[k].e_rdy));
      check($sformatf("tbl%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].e_ov));
      check($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].e_busy));
      check($sformatf("tbl%0d_grant_idx", k), 64'(grant_idx), 64'(tbl[k].e_grant));
      check($sformatf("tbl%0d_out_channel", k), 64'(out_channel), 64'(tbl[k].e_chan));
      check($sformatf("tbl%0d_out_data", k), 64'(out_data), 64'(tbl[k].e_data));
      @(posedge clock);
      @(negedge clock);
    end

    // Single source, five beats.
    do_reset();
    for (int k = 0; k < 5; k++) pend[2].push_back(32'hA0 + 32'(k));
    idx = cyc; first_rdy = -1;
    for (int n = 0; n < 30 && olog.size() < 5; n++) begin
      tick();
      if (first_rdy < 0 && s_rdy[2]) first_rdy = s_cyc;
    end
    check("single_rdy_latency", 64'(first_rdy - idx), 64'd1);
    check("single_count", 64'(olog.size()), 64'd5);
    for (int k = 0; k < olog.size(); k++) begin
      check("single_chan", 64'(olog[k].chan), 64'd2);
      check("single_data", 64'(olog[k].data), 64'(32'hA0 + 32'(k)));
      check("single_cycle", 64'(olog[k].cyc - idx), 64'(2 + k));
    end
    tick();
    check("single_idle_busy", 64'(s_busy), 64'd0);
    check("single_idle_ov", 64'(s_ov), 64'd0);

    // Burst limit with two contending sources.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      pend[0].push_back(beat(0, k));
      pend[1].push_back(beat(1, k));
    end
    for (int n = 0; n < 60 && olog.size() < 24; n++) tick();
    check("burst_count", 64'(olog.size() >= 24), 64'd1);
    for (int k = 0; k < 24 && k < olog.size(); k++) begin
      check("burst_chan", 64'(olog[k].chan), 64'(((k / 8) % 2 == 0) ? 0 : 1));
      check("burst_no_bubble", 64'(olog[k].cyc - olog[0].cyc), 64'(k));
    end

    // Round-robin order on the single-beat instance.
    do_reset();
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < 20; k++) pend[i].push_back(beat(i, k));
    for (int n = 0; n < 40 && olog1.size() < 12; n++) tick();
    check("rr_count", 64'(olog1.size() >= 12), 64'd1);
    for (int k = 0; k < 12 && k < olog1.size(); k++) begin
      check("rr_chan", 64'(olog1[k].chan), 64'(k % NUM_SRC));
      check("rr_no_bubble", 64'(olog1[k].cyc - olog1[0].cyc), 64'(k));
    end

    // Backpressure for three cycles mid-burst.
    do_reset();
    for (int k = 0; k < 6; k++) pend[0].push_back(beat(0, k));
    repeat (3) tick();
    ordy_r = 1'b0;
    repeat (3) begin
      tick();
      check("bp_src_ready", 64'(s_rdy), 64'd0);
      check("bp_out_valid", 64'(s_ov), 64'd1);
      check("bp_out_data", 64'(s_data), 64'(beat(0, 1)));
    end
    ordy_r = 1'b1;
    for (int n = 0; n < 40 && (backlog() > 0 || s_ov); n++) tick();
    repeat (2) tick();
    check("bp_count", 64'(olog.size()), 64'd6);
    for (int k = 0; k < olog.size(); k++)
      check("bp_order", 64'(olog[k].data), 64'(beat(0, k)));

    // Enable drop on the granted source with another source waiting.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pend[1].push_back(beat(1, k));
      pend[3].push_back(beat(3, k));
    end
    repeat (3) tick();
    en_r[1] = 1'b0;
    idx = cyc;
    repeat (6) tick();
    n1 = 0; n3 = 0; first3 = -1;
    foreach (olog[k]) begin
      if (olog[k].chan == 8'd1 && olog[k].cyc > idx) n1++;
      if (olog[k].chan == 8'd3 && first3 < 0) first3 = olog[k].cyc;
      if (olog[k].chan == 8'd3 && olog[k].cyc >= idx + 2 && olog[k].cyc <= idx + 5) n3++;
    end
    check("en_drop_src1_after", 64'(n1 <= 1), 64'd1);
    check("en_drop_first_src3", 64'(first3 - idx), 64'd2);
    check("en_drop_src3_run", 64'(n3), 64'd4);

    // Asynchronous reset with a beat held in the output register.
    do_reset();
    for (int k = 0; k < 10; k++) pend[1].push_back(beat(1, k));
    repeat (3) tick();
    check("areset_pre_ov", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #2;
    check("areset_ov", 64'(out_valid), 64'd0);
    check("areset_src_ready", 64'(src_ready), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_grant", 64'(grant_idx), 64'd0);
    for (int i = 0; i < NUM_SRC; i++) acc_q[i].delete();
    prev_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pend[0].push_back(beat(0, k));
      pend[3].push_back(beat(3, k));
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    olog.delete();
    tick();
    tick();
    check("areset_regrant_busy", 64'(s_busy), 64'd1);
    check("areset_regrant_idx", 64'(s_grant), 64'd0);
    repeat (3) tick();
    check("areset_first_chan", 64'(olog.size() > 0 ? olog[0].chan : 8'hFF), 64'd0);

    // Randomized traffic with stalls, valid gaps and enable changes.
    do_reset();
    tot = 0;
    for (int i = 0; i < NUM_SRC; i++) seqn[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      ordy_r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        vmask[i] = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 49) == 0) en_r[i] = ~en_r[i];
        if (pend[i].size() < 3 && $urandom_range(0, 2) == 0) begin
          pend[i].push_back(beat(i, seqn[i]));
          seqn[i]++;
          tot++;
        end
      end
      tick();
    end
    en_r = '1; vmask = '1; ordy_r = 1'b1;
    for (int n = 0; n < 400 && (backlog() > 0 || s_ov); n++) tick();
    check("rand_drained", 64'(backlog()), 64'd0);
    check("rand_beat_total", 64'(olog.size()), 64'(tot));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m2s_stream_arbiter.md
# m2s_stream_arbiter

Round-robin Avalon-ST arbiter that shares the single memory-to-stream FIFO sink among up to eight streaming sources. It sits directly in front of the FIFO's sink port, tags every beat with the originating source index on the channel field, and forwards each source's error byte. Grants are held for bursts of up to `MAX_BURST` beats to keep per-source data contiguous in the FIFO. A registered output stage decouples source timing from the FIFO's ready path.

## Interface
- `NUM_SRC`, 4: number of sources, 2..8.
- `DATA_W`, 32: beat width, matches the FIFO data width.
- `MAX_BURST`, 8: maximum beats per grant, 1..255.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `src_enable`  in  NUM_SRC  per-source arbitration enable (configuration, quasi-static).
- `src_valid`  in  NUM_SRC  per-source valid.
- `src_data`  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- `src_error`  in  NUM_SRC*8  source i occupies bits [i*8 +: 8].
- `src_ready`  out  NUM_SRC  per-source ready, readyLatency 0.
- `out_valid`  out  1  beat valid toward the FIFO sink.
- `out_data`  out  DATA_W  beat data.
- `out_channel`  out  8  source index, zero-extended.
- `out_error`  out  8  error byte of the source.
- `out_ready`  in  1  FIFO sink ready.
- `busy`  out  1  high while the FSM is in GRANT.
- `grant_idx`  out  3  currently granted index; holds its last value while IDLE.

## Operation
- Eligible source: `src_valid[i] & src_enable[i]`.
- Round-robin search starts at `last_grant+1` and wraps modulo `NUM_SRC`. The lowest index reached first wins.
- FSM has two states, IDLE and GRANT.
- **IDLE**:
  - If any source is eligible, load `grant_idx` with the winner, set `last_grant` to the winner, clear `burst_cnt`, and go to GRANT next cycle.
  - Otherwise stay in IDLE.
  - No beats are accepted in IDLE.
- **GRANT**:
  - `slot_free = ~out_valid | out_ready`.
  - `src_ready[i] = (i == grant_idx) & slot_free`. All other ready bits are 0.
  - Beat accepted when `src_valid[grant_idx] & src_ready[grant_idx]`. On acceptance, the output register loads data, error and channel = `grant_idx`, `out_valid` is set, and `burst_cnt` increments.
- **Release** from GRANT happens in any of these cycles:
  - accepted beat with `burst_cnt == MAX_BURST-1`;
  - `src_valid[grant_idx] == 0`;
  - `src_enable[grant_idx] == 0`.
- **On release**: run the round-robin search in the same cycle, using the just-released index as lowest priority.
  - If a winner exists, stay in GRANT with the new index and `burst_cnt = 0`. There is no bubble cycle.
  - Otherwise go to IDLE.
- **Output register**:
  - `out_valid` clears when `out_ready` is high and no beat is accepted that cycle.
  - Data, channel and error hold while `out_valid & ~out_ready`.
- `burst_cnt` width is 8 bits and never exceeds `MAX_BURST-1`.
- Disabling the granted source forces a release. A beat already in the output register is still delivered.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_channel`=0, `out_error`=0.
  - `src_ready`=0, `busy`=0, `grant_idx`=0.
  - Internal: `last_grant`=`NUM_SRC-1` (so source 0 has first priority), `burst_cnt`=0, state IDLE.
- Latency:
  - First eligible valid to first `src_ready`: 1 cycle (the IDLE→GRANT decision).
  - Accepted beat to `out_valid`: 1 cycle.
- Sustained throughput is 1 beat/cycle while `out_ready` stays high, including across grant changes.
- `out_ready` low stalls the output. `src_ready` drops combinationally in the same cycle, so no beat is lost or duplicated.
- Reset asserted mid-burst clears all state immediately. A beat held in the output register is discarded.
- If `src_valid` and `src_enable` drop in the same cycle for the granted source, only one release happens.

## Test plan
- **Reset, then single source.** Hold source 2 valid with 5 beats 0xA0..0xA4 and `out_ready`=1 → `src_ready[2]` rises one cycle after valid. Five consecutive `out_valid` beats follow, all with `out_channel`=2, then the FSM returns to IDLE.
- **Burst limit.** `MAX_BURST`=8; sources 0 and 1 continuously valid → output channels run 0×8, 1×8, 0×8, with no idle cycle between bursts.
- **Round-robin order.** All four sources valid with `MAX_BURST`=1 → channel sequence 0,1,2,3,0,1,…; source 3 is never starved.
- **Backpressure.** Hold `out_ready` low for 3 cycles mid-burst → `out_data` is stable throughout and `src_ready`=0 throughout. After release the beat count equals the number of source beats, with no duplicates.
- **Enable drop.** Clear `src_enable[1]` during its grant with source 3 valid → at most the in-flight beat from source 1 appears, then channel-3 beats follow on the next cycle.
- **Async reset mid-burst.** Assert `reset` with `out_valid`=1 → `out_valid`, `src_ready` and `busy` go to 0 immediately. After reset release, source 0 is granted first.
